// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: producer-side and transmitter-side signals of the UART transmit arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8
);
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0] grant;
  logic [DATA_W-1:0] tx_data;
  logic tx_start;
  logic tx_busy;
  logic [ID_W-1:0] active_id;
  logic idle;
  modport master (output req, req_data, tx_busy, input grant, tx_data, tx_start, active_id, idle);
  modport slave (input req, req_data, tx_busy, output grant, tx_data, tx_start, active_id, idle);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter; define UART_ARB_TIMEOUT_EN for a busy-rise timeout with sticky timeout_err
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  uart_tx_arbiter_if.slave bus
`ifdef UART_ARB_TIMEOUT_EN
  , output logic timeout_err
`endif
);
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] ptr, sel, idx;
  logic found, launch, tmo;
  // pick the first requester after the last granted one, wrapping round
  always_comb begin
    sel = ptr;
    idx = ptr;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (bus.req[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next state: a launch only ever starts from IDLE with the transmitter free
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = (!bus.tx_busy && found) ? LAUNCH : IDLE;
      LAUNCH: state_nx = WAIT_BUSY;
      WAIT_BUSY: state_nx = bus.tx_busy ? WAIT_DONE : (tmo ? IDLE : WAIT_BUSY);
      default: state_nx = bus.tx_busy ? WAIT_DONE : IDLE;
    endcase
  end
  assign launch = state == IDLE && state_nx == LAUNCH;
  // registered outputs: grant and tx_start pulse for the LAUNCH cycle, byte and id held until the next launch
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.grant <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data <= '0;
      bus.active_id <= '0;
      bus.idle <= 1'b1;
      ptr <= ID_W'(NUM_REQ - 1);
    end else begin
      bus.grant <= launch ? NUM_REQ'(1) << sel : '0;
      bus.tx_start <= launch;
      bus.idle <= state_nx == IDLE;
      if (launch) begin
        bus.tx_data <= bus.req_data[int'(sel)*DATA_W +: DATA_W];
        bus.active_id <= sel;
        ptr <= sel;
      end
    end
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign tmo = state == WAIT_BUSY && !bus.tx_busy && cnt == CW'(BUSY_TIMEOUT - 1);
  // count WAIT_BUSY cycles; a timeout abandons the granted byte and latches the error
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= state == WAIT_BUSY ? cnt + 1'b1 : '0;
      if (tmo) timeout_err <= 1'b1;
    end
`else
  assign tmo = 1'b0;
`endif
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers (e.g. command responder, debug logger, status reporter).
- Selects a requester, latches its byte, pulses the transmitter's transmit input, and tracks busy until the frame completes.
- Acknowledges the requester with a one-cycle grant pulse on byte acceptance.
- Sits between the producer blocks and the UART transmitter on the uart_if clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match the transmitter's TxData width.
- BUSY_TIMEOUT, 16, cycles allowed for tx_busy to rise after tx_start (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req  input  NUM_REQ  per-requester request; held high with data stable until that requester's grant.
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- grant  output  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
- tx_data  output  DATA_W  byte to transmitter TxData; registered, held until the next launch.
- tx_start  output  1  one-cycle pulse to transmitter transmit input.
- tx_busy  input  1  transmitter busy flag.
- active_id  output  $clog2(NUM_REQ)  index of the last granted requester.
- idle  output  1  high when in IDLE.

Behaviour:
- Reset values: grant=0, tx_data=0, tx_start=0, active_id=0, idle=1, state=IDLE, rr pointer=NUM_REQ-1 so requester 0 has first priority.
- All outputs are registered.
- State IDLE:
  - If tx_busy=0 and any req bit is set, select the first set bit, scanning from pointer+1 with wrap-around modulo NUM_REQ.
  - Next cycle (LAUNCH): tx_start=1, grant[sel]=1, tx_data=req_data[sel], active_id=sel, pointer=sel, idle=0.
  - If tx_busy=1 in IDLE, no launch, even with requests pending.
- State LAUNCH: lasts exactly 1 cycle, then WAIT_BUSY.
  - Latency: req sampled high in IDLE at edge N gives tx_start/grant high from edge N+1 for one cycle.
- State WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE.
  - The transmitter raises busy the cycle after transmit, so normally 1 cycle.
- State WAIT_DONE: stay while tx_busy=1; on tx_busy=0 go to IDLE.
  - A new grant can occur at the earliest 1 cycle after returning to IDLE.
  - Back-to-back frames are therefore separated by 2 clk cycles of idle line after the stop bit.
- Fairness: with all requesters continuously asserted, the grant order is 0,1,2,3,0,...
  - No requester is granted twice while another requester is waiting.
- Requester deasserting req before its grant: silently dropped, no grant.
- A req bit that rises during LAUNCH/WAIT_* waits for the next IDLE evaluation.
- grant is never asserted to more than one requester; at most one tx_start per frame.
- Async reset mid-frame: the arbiter returns to reset values immediately.
  - The transmitter may still complete its frame; the arbiter then waits in IDLE for tx_busy=0 before launching.
- NUM_REQ=1: pointer is constant; behaviour otherwise unchanged.

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_BUSY.
  - If tx_busy has not risen after BUSY_TIMEOUT cycles, return to IDLE and set sticky output timeout_err (1 bit, reset 0, extra port).
  - timeout_err clears only on reset.
  - The granted byte is considered consumed and is not retried.
- Not defined:
  - No counter and no timeout_err port.
  - WAIT_BUSY waits indefinitely.

Test Plan:
- Single request: req=4'b0100, req_data[2]=8'hA5 -> one-cycle grant=4'b0100 with tx_start and tx_data=8'hA5; serial frame 0,A5 LSB-first,1; idle=1 after busy falls.
- Fairness: req=4'b1111 held, bytes 8'h10..8'h13 -> grants in order 0,1,2,3,0; exactly one grant per frame; no grant while tx_busy=1.
- Wrap-around: last grant to 3, then req=4'b1001 -> next grant to 0; then with req=4'b1001 still set -> grant to 3.
- Drop: req[1] pulsed high during WAIT_DONE and low before IDLE -> grant[1] never asserted; tx_start count unchanged.
- Reset mid-frame: reset=0 for 3 cycles during WAIT_DONE -> all outputs at reset values; with req=4'b0001 and tx_busy still 1, no tx_start until tx_busy=0, then grant[0] one cycle later.
- UART_ARB_TIMEOUT_EN: tx_busy tied 0, req=4'b0001 -> tx_start once; timeout_err=1 after 16 WAIT_BUSY cycles; state returns to IDLE and the next grant goes to requester 0.
